// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
// States, frame bytes and default sizing.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        RESP,
        RUN
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    localparam int MAX_WORDS_DEF = 16384;
    localparam int TIMEOUT_DEF   = 1000000;

endpackage

// File: rtl/ld_timeout.sv
// Reloadable down-counter for the inter-byte timeout.
// expire_o pulses after TIMEOUT enabled cycles without a reload.
module ld_timeout #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic reload_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i & ~reload_i & (cnt_q == '0);

    // Reload on activity, otherwise count down while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = LOAD;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// UART program loader: parses framed payload into BRAM writes,
// verifies an XOR checksum, answers ACK/NAK and releases the CPU.
module prog_loader
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] addr,
    output logic [3:0]  we,
    output logic [31:0] din,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        err,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    state_e      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [15:0] widx_q, widx_d;
    logic [31:0] din_q, din_d;
    logic [15:0] addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic        err_q, err_d;
    logic [7:0]  tx_q, tx_d;
    logic        busy;
    logic        tmo;
    logic [15:0] n_full;

    assign busy = (state_q == LEN0) || (state_q == LEN1) ||
                  (state_q == DATA) || (state_q == CSUM);
    assign n_full = {rx_data, n_q[7:0]};

    ld_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .en_i     (busy),
        .reload_i (rx_valid | ~busy),
        .expire_o (tmo)
    );

    // Frame parser: next state and datapath updates.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        csum_d  = csum_q;
        bcnt_d  = bcnt_q;
        widx_d  = widx_q;
        din_d   = din_q;
        addr_d  = addr_q;
        we_d    = 4'h0;
        err_d   = err_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = LEN0;
                    csum_d  = 8'h00;
                    bcnt_d  = 2'd0;
                    widx_d  = 16'd0;
                    err_d   = 1'b0;
                end
            end
            LEN0: begin
                if (rx_valid) begin
                    n_d[7:0] = rx_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                if (rx_valid) begin
                    n_d[15:8] = rx_data;
                    if (32'(n_full) > 32'(MAX_WORDS)) begin
                        state_d = RESP;
                        tx_d    = NAK_BYTE;
                        err_d   = 1'b1;
                    end else if (n_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    din_d[{bcnt_q, 3'b000} +: 8] = rx_data;
                    csum_d = csum_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d   = 4'hF;
                        addr_d = {widx_q[13:0], 2'b00};
                        widx_d = widx_q + 16'd1;
                        if (widx_q == n_q - 16'd1) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    state_d = RESP;
                    if (rx_data == csum_q) begin
                        tx_d = ACK_BYTE;
                    end else begin
                        tx_d  = NAK_BYTE;
                        err_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (tx_ready) begin
                    state_d = (tx_q == ACK_BYTE) ? RUN : IDLE;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A stalled sender abandons the frame silently.
        if (busy && tmo) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            csum_q  <= '0;
            bcnt_q  <= '0;
            widx_q  <= '0;
            din_q   <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            err_q   <= 1'b0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            csum_q  <= csum_d;
            bcnt_q  <= bcnt_d;
            widx_q  <= widx_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            err_q   <= err_d;
            tx_q    <= tx_d;
        end
    end

    assign addr      = addr_q;
    assign we        = we_q;
    assign din       = din_q;
    assign cpu_rst_n = (state_q == RUN);
    assign done      = (state_q == RUN);
    assign err       = err_q;
    assign tx_data   = tx_q;
    assign tx_valid  = (state_q == RESP);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with hand-computed frames.
// Writes are logged at negedge and compared after each frame.
module tb_prog_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic        cpu_rst_n;
    logic        done;
    logic        err;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int bad_we = 0;
    int txv_cnt = 0;
    logic [15:0] wa[$];
    logic [31:0] wd[$];

    prog_loader #(
        .MAX_WORDS (16384),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr      (addr),
        .we        (we),
        .din       (din),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    // Log BRAM writes and count illegal enable patterns.
    always @(negedge clk) begin
        if (we !== 4'h0) begin
            wa.push_back(addr);
            wd.push_back(din);
            if (we !== 4'hF) bad_we++;
        end
        if (tx_valid === 1'b1) txv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        wa.delete();
        wd.delete();
        txv_cnt = 0;
    endtask

    task automatic chk_wr(input int i, input logic [15:0] a,
                          input logic [31:0] d);
        if (i < wa.size()) begin
            chk($sformatf("wr%0d_addr", i), 32'(wa[i]), 32'(a));
            chk($sformatf("wr%0d_din", i), wd[i], d);
        end else begin
            chk($sformatf("wr%0d_missing", i), 0, 1);
        end
    endtask

    // One edge of reset, then check every output.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_addr", 32'(addr), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_din", din, 0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t f);
        foreach (f[i]) send(f[i]);
    endtask

    // Wait for a response, optionally stall, then handshake.
    task automatic get_resp(input string tag, input logic [7:0] exp,
                            input int hold);
        int  n;
        logic ok;
        n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (tx_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_txv"}, 32'(tx_valid), 1);
        chk({tag, "_txd"}, 32'(tx_data), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== exp) ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_stall"}, 32'(ok), 1);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_txv_off"}, 32'(tx_valid), 0);
    endtask

    bq_t f1 = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    bq_t f2 = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    bq_t f3 = '{8'hA5, 8'h00, 8'h00, 8'h00};
    bq_t f4 = '{8'hA5, 8'h01, 8'h40};
    bq_t f5 = '{8'hA5, 8'h01, 8'h00, 8'h12};
    bq_t f6 = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    bq_t junk = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Single word, response stalled 10 cycles.
        clr_log();
        send_frame(f1);
        get_resp("t1", 8'h06, 10);
        chk("t1_nwr", wa.size(), 1);
        chk_wr(0, 16'h0000, 32'h12345678);
        chk("t1_cpu_rst_n", 32'(cpu_rst_n), 1);
        chk("t1_done", 32'(done), 1);
        chk("t1_err", 32'(err), 0);
        clr_log();
        send_frame(junk);
        repeat (3) @(negedge clk);
        chk("t1_run_nwr", wa.size(), 0);
        chk("t1_run_done", 32'(done), 1);
        chk("t1_run_txv", txv_cnt, 0);

        // Two words, bad checksum, then a retry overwrites.
        do_reset();
        clr_log();
        send_frame(f2);
        get_resp("t2", 8'h15, 0);
        chk("t2_nwr", wa.size(), 2);
        chk_wr(0, 16'h0000, 32'h44332211);
        chk_wr(1, 16'h0004, 32'h88776655);
        chk("t2_err", 32'(err), 1);
        chk("t2_cpu_rst_n", 32'(cpu_rst_n), 0);
        chk("t2_done", 32'(done), 0);
        clr_log();
        send_frame(f1);
        get_resp("t2r", 8'h06, 0);
        chk_wr(0, 16'h0000, 32'h12345678);
        chk("t2r_err", 32'(err), 0);
        chk("t2r_done", 32'(done), 1);

        // Empty program.
        do_reset();
        clr_log();
        send_frame(f3);
        get_resp("t3", 8'h06, 0);
        chk("t3_nwr", wa.size(), 0);
        chk("t3_cpu_rst_n", 32'(cpu_rst_n), 1);

        // Length one past the limit.
        do_reset();
        clr_log();
        send_frame(f4);
        get_resp("t4", 8'h15, 0);
        chk("t4_nwr", wa.size(), 0);
        chk("t4_err", 32'(err), 1);
        chk("t4_cpu_rst_n", 32'(cpu_rst_n), 0);

        // Inter-byte timeout at exactly 16 idle cycles.
        do_reset();
        clr_log();
        send_frame(f5);
        repeat (15) @(posedge clk);
        #1;
        chk("t5_err_early", 32'(err), 0);
        @(posedge clk);
        #1;
        chk("t5_err", 32'(err), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_txv", txv_cnt, 0);
        chk("t5_nwr", wa.size(), 0);
        chk("t5_cpu_rst_n", 32'(cpu_rst_n), 0);
        send(8'hA5);
        chk("t5_err_clr", 32'(err), 0);
        send_frame('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08});
        get_resp("t5r", 8'h06, 0);
        chk_wr(0, 16'h0000, 32'h12345678);
        chk("t5r_done", 32'(done), 1);

        // Reset in the middle of a word.
        clr_log();
        do_reset();
        send_frame(f6);
        chk("t6_din_partial", din, 32'h00002211);
        do_reset();
        chk("t6_nwr", wa.size(), 0);

        chk("bad_we", bad_we, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
